analsy_len: RTL and testbench



---
 rtl/analsy_len.sv | 123 ++++++++++++
 tb/tb_analsy_len.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/analsy_len.sv
// analsy_len: iterative MSB-first bit-length analyser. It examines CHUNK = 2**EXPAND_LEVEL bits per clock and stops early.
// Optional macro ANALSY_LEN_HOLD_READY_EN: result_ready stays high from completion until the next accepted start.
module analsy_len #(
    parameter int BUS_WIDTH    = 64,
    parameter int EXPAND_LEVEL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] din,
    input  logic                 we,
    output logic                 result_ready,
    output logic                 busy,
    output logic [BUS_WIDTH-1:0] result
);
    localparam int CHUNK  = 1 << EXPAND_LEVEL;
    localparam int NCHUNK = BUS_WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LZ_W   = EXPAND_LEVEL + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BUS_WIDTH-1:0] r_sr;
    logic [BUS_WIDTH-1:0] r_result;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ready;

    logic [CHUNK-1:0]     w_chunk;
    logic [LZ_W-1:0]      w_lz;
    logic [31:0]          w_len;
    logic                 w_hit;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_done;

    assign w_chunk  = r_sr[BUS_WIDTH-1 -: CHUNK];
    assign w_hit    = |w_chunk;
    assign w_last   = (r_cnt == CNT_W'(NCHUNK - 1));
    assign w_accept = (r_state == ST_IDLE) && we;
    assign w_done   = (r_state == ST_SCAN) && (w_hit || w_last);

    // Leading-zero count inside the top chunk. The highest set bit is visited last, so it wins.
    always_comb begin
        // NOTE: assign the default before the loop so every path drives w_lz and no latch is inferred.
        w_lz = LZ_W'(CHUNK);
        for (int i = 0; i < CHUNK; i++) begin
            if (w_chunk[i]) begin
                w_lz = LZ_W'(CHUNK - 1 - i);
            end
        end
    end

    assign w_len = 32'(BUS_WIDTH) - (32'(r_cnt) << EXPAND_LEVEL) - 32'(w_lz);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (we)             w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_hit || w_last) w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy         = (r_state == ST_SCAN);
        result_ready = r_ready;
        result       = r_result;
    end

    // Datapath: the shift register brings the next chunk to the top on each empty scan step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_sr  <= din;
            r_cnt <= '0;
        end else if (r_state == ST_SCAN) begin
            if (w_hit) begin
                r_result <= BUS_WIDTH'(w_len);
            end else if (w_last) begin
                r_result <= '0;
            end else begin
                r_sr  <= r_sr << CHUNK;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
        end else begin
`ifdef ANALSY_LEN_HOLD_READY_EN
            if (w_done) begin
                r_ready <= 1'b1;
            end else if (w_accept) begin
                r_ready <= 1'b0;
            end
`else
            r_ready <= w_done;
`endif
        end
    end

endmodule

// File: tb/tb_analsy_len.sv
// Testbench for analsy_len. A scoreboard queue is fed by the stimulus and drained by a negedge monitor.
// A second group of instances covers the EXPAND_LEVEL sweep.
module tb_analsy_len;
    localparam int W        = 64;
    localparam int MAIN_LVL = 1;
    localparam int SW_LVL [3] = '{0, 2, 3};

    typedef struct {
        int len;
        int due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         we;
    logic         result_ready;
    logic         busy;
    logic [W-1:0] result;

    logic [W-1:0] din_s;
    logic [2:0]   we_s;
    logic [2:0]   rdy_s;
    logic [2:0]   busy_s;
    logic [W-1:0] res_s [3];

    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   last_done = 0;
    exp_t sb_q[$];
    logic prev_ready = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    analsy_len #(.BUS_WIDTH(W), .EXPAND_LEVEL(MAIN_LVL)) u_dut (
        .clk(clk), .rst(rst), .din(din), .we(we),
        .result_ready(result_ready), .busy(busy), .result(result)
    );
    analsy_len #(.BUS_WIDTH(W), .EXPAND_LEVEL(0)) u_l0 (
        .clk(clk), .rst(rst), .din(din_s), .we(we_s[0]),
        .result_ready(rdy_s[0]), .busy(busy_s[0]), .result(res_s[0])
    );
    analsy_len #(.BUS_WIDTH(W), .EXPAND_LEVEL(2)) u_l2 (
        .clk(clk), .rst(rst), .din(din_s), .we(we_s[1]),
        .result_ready(rdy_s[1]), .busy(busy_s[1]), .result(res_s[1])
    );
    analsy_len #(.BUS_WIDTH(W), .EXPAND_LEVEL(3)) u_l3 (
        .clk(clk), .rst(rst), .din(din_s), .we(we_s[2]),
        .result_ready(rdy_s[2]), .busy(busy_s[2]), .result(res_s[2])
    );

    task automatic check(input bit ok, input string name, input int act, input int exp_v);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference model: bit length is the position of the highest set bit plus one.
    function automatic int ref_len(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) begin
            if (d[i]) return i + 1;
        end
        return 0;
    endfunction

    // Scan cycles from the start edge to the completing edge.
    function automatic int ref_lat(input int len, input int chunk);
        return (len == 0) ? W / chunk : (W - len) / chunk + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a start. The model decides whether the DUT is free at the next edge.
    task automatic start(input logic [W-1:0] d);
        exp_t e;
        we  = 1'b1;
        din = d;
        if (cyc + 1 > last_done) begin
            e.len     = ref_len(d);
            e.due     = cyc + 1 + ref_lat(e.len, 1 << MAIN_LVL);
            last_done = e.due;
            sb_q.push_back(e);
        end
        tick();
        we = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc <= last_done) tick();
    endtask

    task automatic run_sweep(input logic [W-1:0] d);
        int lat [3];
        int len;
        len   = ref_len(d);
        lat   = '{0, 0, 0};
        din_s = d;
        we_s  = 3'b111;
        tick();
        we_s  = 3'b000;
        for (int c = 1; c <= W + 2; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (rdy_s[i] && lat[i] == 0) begin
                    lat[i] = c;
                    check(int'(res_s[i]) == len, $sformatf("sweep_result_lvl%0d", SW_LVL[i]),
                          int'(res_s[i]), len);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check(lat[i] == ref_lat(len, 1 << SW_LVL[i]), $sformatf("sweep_latency_lvl%0d", SW_LVL[i]),
                  lat[i], ref_lat(len, 1 << SW_LVL[i]));
        end
        check(busy_s == 3'b000, "sweep_busy_idle", int'(busy_s), 0);
    endtask

    // Monitor: every completion pops one expectation and compares value and cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   evt;
`ifdef ANALSY_LEN_HOLD_READY_EN
        evt = result_ready && !prev_ready;
`else
        evt = result_ready;
`endif
        prev_ready = result_ready;
        if (!rst) begin
            if (evt) begin
                if (sb_q.size() == 0) begin
                    check(1'b0, "unexpected_ready", int'(result), -1);
                end else begin
                    e = sb_q.pop_front();
                    check(int'(result) == e.len, "result", int'(result), e.len);
                    check(cyc == e.due, "ready_cycle", cyc, e.due);
                end
            end else if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
                check(1'b0, "missing_ready", cyc, sb_q[0].due);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] d;
        int n;
        int p;
        int mode;

        rst  = 1'b1;
        we   = 1'b0;
        din  = '0;
        we_s = 3'b000;
        din_s = '0;
        repeat (2) tick();
        rst = 1'b0;
        check(busy == 1'b0, "reset_busy", int'(busy), 0);
        check(result_ready == 1'b0, "reset_ready", int'(result_ready), 0);
        check(int'(result) == 0, "reset_result", int'(result), 0);

        // Reference vector: the top set bit is bit 42.
        d = {20'h0, 6'b010010, 36'h012345678, 2'b00};
        start(d);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        check(n == ref_lat(ref_len(d), 2), "busy_cycles", n, ref_lat(ref_len(d), 2));
        repeat (3) tick();
        check(int'(result) == ref_len(d), "result_hold", int'(result), ref_len(d));

        // Boundary vectors: MSB set, LSB only, and all zero.
        start(64'h8000_0000_0000_0000);
        check(int'(result) == ref_len(d), "result_kept_on_start", int'(result), ref_len(d));
        wait_idle();
        start(64'h1);
        wait_idle();
        start(64'h0);
        wait_idle();

        // A start while busy is ignored. A start in the ready cycle is accepted.
        start(64'h0);
        repeat (5) tick();
        start('1);
        check(busy == (cyc < last_done), "busy_during_ignored_we", int'(busy), int'(cyc < last_done));
        while (cyc < last_done) tick();
        check(result_ready == 1'b1, "ready_cycle_visible", int'(result_ready), 1);
        start('1);
        wait_idle();

        // Reset in the middle of a scan aborts it.
        start(64'h1);
        repeat (4) tick();
        rst = 1'b1;
        sb_q.delete();
        last_done = 0;
        tick();
        rst = 1'b0;
        check(busy == 1'b0, "abort_busy", int'(busy), 0);
        check(result_ready == 1'b0, "abort_ready", int'(result_ready), 0);
        check(int'(result) == 0, "abort_result", int'(result), 0);
        repeat (40) tick();
        start(64'h100);
        wait_idle();

        // Random traffic with idle gaps, back-to-back starts and starts while busy.
        for (int t = 0; t < 40; t++) begin
            p = $urandom_range(0, W);
            if (p == W) d = '0;
            else d = (64'd1 << p) | ({$urandom, $urandom} & ((64'd1 << p) - 64'd1));
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                while (cyc < last_done) tick();
            end else if (mode >= 2) begin
                wait_idle();
                repeat ($urandom_range(0, 2)) tick();
            end
            start(d);
        end
        wait_idle();

        // Sweep of the scan width on separate instances.
        run_sweep(64'h0000_0400_0000_0000);
        run_sweep({$urandom, $urandom} >> $urandom_range(0, 63));
        run_sweep(64'h0);

        repeat (3) tick();
        check(sb_q.size() == 0, "scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
